alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe_if.sv | 27 ++
 rtl/alu_pipe.sv | 135 +++++++++++++
 tb/tb_alu_pipe.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Handshake bundle for alu_pipe: an operand beat going in, a result beat
// coming out, each with its own valid/ready pair.
interface alu_pipe_if #(
   parameter int N = 16
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [2:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] result;
   logic         carry;
   logic         ovf;
   logic         zero;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, carry, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, carry, ovf, zero
   );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: S1 latches operands, S2 latches the result and
// flags. Add/sub can wrap around or saturate, depending on SAT.
module alu_pipe #(
   parameter int N   = 16,
   parameter bit SAT = 1'b0
) (
   input logic       clk,
   input logic       rst,
   alu_pipe_if.slave bus
);
   localparam int SW = $clog2(N);

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SHL = 3'd5,
      OP_SHR = 3'd6,
      OP_SRA = 3'd7
   } op_e;

   if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
      $error("alu_pipe: N must be a power of two and at least 4");
   end

   logic         s1_valid;
   logic [N-1:0] s1_a;
   logic [N-1:0] s1_b;
   op_e          s1_op;

   logic         s2_valid;
   logic [N-1:0] s2_result;
   logic         s2_carry;
   logic         s2_ovf;
   logic         s2_zero;

   logic         s2_advance;
   logic         in_ready;

   // S2 can take a new beat when it is empty or its beat leaves this cycle.
   // A full S1 therefore never blocks a simultaneous in/out handshake.
   assign s2_advance = !s2_valid || bus.out_ready;
   assign in_ready   = !rst && (!s1_valid || s2_advance);

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = s2_valid;
   assign bus.result    = s2_result;
   assign bus.carry     = s2_carry;
   assign bus.ovf       = s2_ovf;
   assign bus.zero      = s2_zero;

   // NOTE: state uses non-blocking assignments so every register samples
   // pre-edge values, whatever order the always_ff blocks happen to run in.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (in_ready) begin
         s1_valid <= bus.in_valid;
      end
   end

   // NOTE: operand registers are deliberately left without a reset; only the
   // valid bits decide whether their contents mean anything.
   always_ff @(posedge clk) begin
      if (in_ready && bus.in_valid) begin
         s1_a  <= bus.a;
         s1_b  <= bus.b;
         s1_op <= op_e'(bus.op);
      end
   end

   logic [N:0]    sum_ext;
   logic [N-1:0]  alu_res;
   logic          alu_carry;
   logic          alu_ovf;
   logic [SW-1:0] shamt;

   // NOTE: every output of this block gets a default first, so no path
   // through the case can leave a value held and infer a latch.
   always_comb begin
      sum_ext   = '0;
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      shamt     = s1_b[SW-1:0];

      unique case (s1_op)
         OP_ADD: begin
            sum_ext   = {1'b0, s1_a} + {1'b0, s1_b};
            alu_res   = sum_ext[N-1:0];
            alu_carry = sum_ext[N];
            alu_ovf   = (s1_a[N-1] == s1_b[N-1]) && (alu_res[N-1] != s1_a[N-1]);
         end
         OP_SUB: begin
            // Bit N of the extended difference is the unsigned borrow.
            sum_ext   = {1'b0, s1_a} - {1'b0, s1_b};
            alu_res   = sum_ext[N-1:0];
            alu_carry = sum_ext[N];
            alu_ovf   = (s1_a[N-1] != s1_b[N-1]) && (alu_res[N-1] != s1_a[N-1]);
         end
         OP_AND: alu_res = s1_a & s1_b;
         OP_OR:  alu_res = s1_a | s1_b;
         OP_XOR: alu_res = s1_a ^ s1_b;
         OP_SHL: alu_res = s1_a << shamt;
         OP_SHR: alu_res = s1_a >> shamt;
         OP_SRA: alu_res = $unsigned($signed(s1_a) >>> shamt);
      endcase

      // An overflow can only push the result away from the sign of a, so
      // that sign alone picks which rail to clamp to.
      if (SAT && alu_ovf) begin
         alu_res = s1_a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_carry  <= 1'b0;
         s2_ovf    <= 1'b0;
         s2_zero   <= 1'b0;
      end else if (s2_advance) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_result <= alu_res;
            s2_carry  <= alu_carry;
            s2_ovf    <= alu_ovf;
            s2_zero   <= (alu_res == '0);
         end
      end
   end
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe. It runs a wrap-around and a saturating
// instance side by side on identical stimulus.
module tb_alu_pipe;
   localparam int N = 16;

   typedef struct {
      logic [N-1:0] res;
      logic         c;
      logic         v;
      logic         z;
      int           acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_pipe_if #(.N(N)) if0 ();
   alu_pipe_if #(.N(N)) if1 ();

   alu_pipe #(.N(N), .SAT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   alu_pipe #(.N(N), .SAT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

   exp_t         sb_q[2][$];
   int           n_checks = 0;
   int           n_errors = 0;
   int           cyc = 0;
   bit           lat_check = 1'b0;
   bit           rnd_done = 1'b0;
   bit           prev_stall[2];
   logic [N-1:0] prev_res[2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model in plain integer arithmetic.
   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic [2:0] op, input bit sat);
      exp_t   e;
      longint ua, ub, sa, sb, u, s;
      int     sh;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      u  = 0;
      s  = 0;
      sh = int'(b[3:0]);
      e.res = '0;
      e.c   = 1'b0;
      e.v   = 1'b0;
      e.acc = 0;
      case (op)
         3'd0: begin
            u = ua + ub; s = sa + sb;
            e.c = (u > 65535); e.v = (s > 32767) || (s < -32768); e.res = u[15:0];
         end
         3'd1: begin
            u = ua - ub; s = sa - sb;
            e.c = (ua < ub); e.v = (s > 32767) || (s < -32768); e.res = u[15:0];
         end
         3'd2: e.res = a & b;
         3'd3: e.res = a | b;
         3'd4: e.res = a ^ b;
         3'd5: e.res = a << sh;
         3'd6: e.res = a >> sh;
         default: begin
            s = sa >>> sh; e.res = s[15:0];
         end
      endcase
      if (sat && e.v) e.res = (s > 0) ? 16'h7FFF : 16'h8000;
      e.z = (e.res == '0);
      return e;
   endfunction

   task automatic set_ready(input bit r);
      if0.out_ready = r;
      if1.out_ready = r;
   endtask

   task automatic drive(input bit v, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2:0] op);
      if0.in_valid = v; if0.a = a; if0.b = b; if0.op = op;
      if1.in_valid = v; if1.a = a; if1.b = b; if1.op = op;
   endtask

   // Offer one beat and hold it until accepted; called just after a posedge.
   task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
      bit   ok = 1'b0;
      exp_t e0, e1;
      drive(1'b1, a, b, op);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (if0.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("send_accept", ok, 1);
      if (ok) begin
         e0 = model(a, b, op, 1'b0); e0.acc = cyc;
         e1 = model(a, b, op, 1'b1); e1.acc = cyc;
         sb_q[0].push_back(e0);
         sb_q[1].push_back(e1);
      end
      @(posedge clk);
      #1;
      drive(1'b0, N'($urandom), N'($urandom), 3'($urandom));
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && (sb_q[0].size() != 0 || sb_q[1].size() != 0); i++)
         @(posedge clk);
      check("drain", sb_q[0].size() + sb_q[1].size(), 0);
      #1;
   endtask

   task automatic mon(input int k, input logic ov, input logic ordy, input logic [N-1:0] res,
                      input logic c, input logic v, input logic z);
      exp_t e;
      if (rst) begin
         prev_stall[k] = 1'b0;
         return;
      end
      if (prev_stall[k]) begin
         check($sformatf("d%0d_hold_valid", k), ov, 1);
         check($sformatf("d%0d_hold_result", k), res, prev_res[k]);
      end
      if (ov && ordy) begin
         if (sb_q[k].size() == 0) begin
            check($sformatf("d%0d_unexpected_beat", k), ov, 0);
         end else begin
            e = sb_q[k].pop_front();
            check($sformatf("d%0d_result", k), res, e.res);
            check($sformatf("d%0d_carry", k), c, e.c);
            check($sformatf("d%0d_ovf", k), v, e.v);
            check($sformatf("d%0d_zero", k), z, e.z);
            if (lat_check) check($sformatf("d%0d_latency", k), cyc - e.acc, 2);
         end
      end
      prev_stall[k] = ov && !ordy;
      prev_res[k]   = res;
   endtask

   always @(negedge clk) begin
      mon(0, if0.out_valid, if0.out_ready, if0.result, if0.carry, if0.ovf, if0.zero);
      mon(1, if1.out_valid, if1.out_ready, if1.result, if1.carry, if1.ovf, if1.zero);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time %0t reached, required finish before 200000", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t b1_0, b1_1;
      rst = 1'b1;
      drive(1'b0, '0, '0, '0);
      set_ready(1'b1);

      // Reset state
      idle(2);
      @(negedge clk);
      check("rst_in_ready0", if0.in_ready, 0);
      check("rst_in_ready1", if1.in_ready, 0);
      check("rst_out_valid0", if0.out_valid, 0);
      check("rst_out_valid1", if1.out_valid, 0);
      check("rst_result", if0.result, 0);
      check("rst_flags", {if0.carry, if0.ovf, if0.zero}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", if0.in_ready, 1);
      idle(1);

      // Directed corner cases, no backpressure
      lat_check = 1'b1;
      send(16'hFFFF, 16'h0001, 3'd0);
      send(16'h8000, 16'h0001, 3'd1);
      send(16'h7FFF, 16'h0001, 3'd0);
      send(16'h8000, 16'h8000, 3'd0);
      send(16'h0001, 16'h0002, 3'd1);
      send(16'h8000, 16'h0004, 3'd7);
      send(16'h0003, 16'h0011, 3'd5);
      send(16'hF0F0, 16'h0013, 3'd6);
      send(16'hA5A5, 16'h0FF0, 3'd2);
      send(16'hA5A5, 16'h0FF0, 3'd3);
      send(16'hA5A5, 16'hA5A5, 3'd4);
      wait_drain();

      // Ten back-to-back beats, each checked for a latency of exactly two
      for (int i = 0; i < 10; i++)
         send(N'($urandom), N'($urandom), 3'($urandom_range(0, 7)));
      wait_drain();
      lat_check = 1'b0;

      // Backpressure: three beats offered, output stalled for five cycles
      set_ready(1'b0);
      b1_0 = model(16'h1234, 16'h1111, 3'd0, 1'b0);
      b1_1 = model(16'h1234, 16'h1111, 3'd0, 1'b1);
      fork
         begin
            send(16'h1234, 16'h1111, 3'd0);
            send(16'h0005, 16'h0009, 3'd1);
            send(16'h00FF, 16'h0F0F, 3'd4);
         end
      join_none
      repeat (3) @(posedge clk);
      #1;
      repeat (5) begin
         @(negedge clk);
         check("bp_in_ready", if0.in_ready, 0);
         check("bp_out_valid", if0.out_valid, 1);
         check("bp_held_result0", if0.result, b1_0.res);
         check("bp_held_result1", if1.result, b1_1.res);
      end
      @(posedge clk);
      #1 set_ready(1'b1);
      #1 check("bp_simul_in_ready", if0.in_ready, 1);
      wait fork;
      wait_drain();

      // Random traffic with random backpressure and idle gaps
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               if ($urandom_range(0, 3) == 0) idle(1);
               send(N'($urandom), ($urandom_range(0, 1) != 0) ? N'($urandom_range(0, 20)) : N'($urandom),
                    3'($urandom_range(0, 7)));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1 set_ready($urandom_range(0, 2) != 0);
            end
         end
      join
      set_ready(1'b1);
      wait_drain();

      // Reset pulse with two beats in flight
      set_ready(1'b0);
      send(16'h1111, 16'h2222, 3'd0);
      send(16'h3333, 16'h4444, 3'd3);
      rst = 1'b1;
      sb_q[0].delete();
      sb_q[1].delete();
      @(negedge clk);
      check("midrst_in_ready", if0.in_ready, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      set_ready(1'b1);
      @(negedge clk);
      check("midrst_out_valid0", if0.out_valid, 0);
      check("midrst_out_valid1", if1.out_valid, 0);
      check("midrst_in_ready_after", if0.in_ready, 1);
      repeat (5) begin
         @(negedge clk);
         check("midrst_no_stale", if0.out_valid, 0);
      end
      @(posedge clk);
      #1;
      send(16'h0010, 16'h0020, 3'd0);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
